// File: rtl/ifetch_unit_pkg.sv
// Shared constants, the instruction-queue entry layout and small PC helpers
// for the instruction-fetch stage.
package ifetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          INST_WIDTH       = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [31:0]           pc;
    logic [31:0]           pc4;
  } inst_entry_t;

  localparam int ENTRY_WIDTH = $bits(inst_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] seq_pc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO built as a shift register so the head is
// always a flop; clear wins over push and pop.
module ifetch_fifo #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [WIDTH-1:0] data_s [DEPTH];
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic [CW-1:0]    wr_idx_s;
  logic             valid_r;
  logic             do_pop_s;
  logic             do_push_s;

  // Next-state shift/insert of the storage and occupancy
  always_comb begin
    do_pop_s  = pop && valid_r;
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    wr_idx_s  = do_pop_s ? (count_r - CW'(1)) : count_r;
    count_s   = count_r + CW'(do_push_s) - CW'(do_pop_s);
    for (int i = 0; i < DEPTH; i++) begin
      data_s[i] = (do_push_s && (wr_idx_s == CW'(i))) ? wdata :
                  do_pop_s ? data_r[(i + 1) % DEPTH] : data_r[i];
    end
  end

  // Storage, occupancy and head-valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
      valid_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= RST_VAL;
      end
    end else if (clear) begin
      count_r <= '0;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_s;
      valid_r <= (count_s != '0);
      data_r  <= data_s;
    end
  end

  assign head  = data_r[0];
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: credit-limited word fetch from instruction memory,
// in-order instruction queue toward decode, redirect with response dropping.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_i,
  input  logic        redirect_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] pc4_o,
  input  logic        inst_ready_i
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int IW  = CW + 3;
  localparam int CRW = CW + 1;
  localparam logic [ENTRY_WIDTH-1:0] HEAD_RST = {NOP_INST, 32'h0000_0000, 32'h0000_0004};

  logic [31:0]   pc_r;
  logic [IW-1:0] inflight_r;
  logic [IW-1:0] drop_r;

  logic          grant_s;
  logic          accept_s;
  logic          pop_s;
  logic [CRW-1:0] credit_s;
  logic [31:0]   tag_head_s;
  logic          tag_valid_s;
  logic [CW-1:0] tag_count_s;
  logic [CW-1:0] inst_count_s;
  inst_entry_t   push_entry_s;
  inst_entry_t   head_s;

  // Issue credit, handshakes and the entry pushed on an accepted response.
  // The tag queue holds exactly the outstanding non-dropped requests, so its
  // count equals inflight minus drop.
  always_comb begin
    credit_s     = CRW'(inst_count_s) + CRW'(tag_count_s);
    imem_req_o   = !rst && !redirect_i && (credit_s < CRW'(DEPTH));
    grant_s      = imem_req_o && imem_gnt_i;
    accept_s     = imem_rvalid_i && (drop_r == {IW{1'b0}}) && tag_valid_s;
    pop_s        = inst_valid_o && inst_ready_i;
    push_entry_s = '{inst: imem_rdata_i, pc: tag_head_s, pc4: seq_pc(tag_head_s)};
  end

  // Fetch PC, outstanding-request and drop counters.
  // drop only counts a subset of inflight, so on redirect everything still
  // outstanding after this edge is inflight minus this cycle's response.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= word_align(RESET_PC);
      inflight_r <= '0;
      drop_r     <= '0;
    end else begin
      inflight_r <= inflight_r + IW'(grant_s) - IW'(imem_rvalid_i);
      if (redirect_i) begin
        pc_r   <= word_align(npc_i);
        drop_r <= inflight_r - IW'(imem_rvalid_i);
      end else begin
        pc_r   <= grant_s ? seq_pc(pc_r) : pc_r;
        drop_r <= drop_r - IW'(imem_rvalid_i && (drop_r != {IW{1'b0}}));
      end
    end
  end

  assign imem_addr_o = word_align(pc_r);

  ifetch_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   (32),
    .RST_VAL (32'h0000_0000)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_s),
    .pop   (accept_s),
    .clear (redirect_i),
    .wdata (pc_r),
    .head  (tag_head_s),
    .valid (tag_valid_s),
    .count (tag_count_s)
  );

  ifetch_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   (ENTRY_WIDTH),
    .RST_VAL (HEAD_RST)
  ) u_inst_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept_s),
    .pop   (pop_s),
    .clear (redirect_i),
    .wdata (push_entry_s),
    .head  (head_s),
    .valid (inst_valid_o),
    .count (inst_count_s)
  );

  assign inst_o    = head_s.inst;
  assign inst_pc_o = head_s.pc;
  assign pc4_o     = head_s.pc4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios then random traffic,
// compared against a request/queue-level reference model.
module tb_ifetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_i;
  logic        redirect_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] pc4_o;
  logic        inst_ready_i;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .npc_i(npc_i), .redirect_i(redirect_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .pc4_o(pc4_o), .inst_ready_i(inst_ready_i)
  );

  typedef struct { logic [31:0] addr; bit alive; int due; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

  req_t        pend[$];
  ent_t        outq[$];
  logic [31:0] pc_m;
  int          cyc;
  int          total;
  int          bad;
  int          lat_max;
  bit          rnd_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int alive_cnt();
    int n;
    n = 0;
    foreach (pend[i]) if (pend[i].alive) n++;
    return n;
  endfunction

  task automatic model_reset();
    pend.delete();
    outq.delete();
    pc_m = RPC;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit r, input bit rd, input logic [31:0] npc, input bit rdy, input bit g);
    bit          exp_req;
    bit          rv_now;
    logic [31:0] rdata_now;
    req_t        p;
    rst          = r;
    redirect_i   = rd;
    npc_i        = npc;
    inst_ready_i = rdy;
    imem_gnt_i   = g;
    rv_now = !r && (pend.size() != 0) && (pend[0].due <= cyc) &&
             (!rnd_rv || ($urandom_range(0, 3) != 0));
    rdata_now     = $urandom();
    imem_rvalid_i = rv_now;
    imem_rdata_i  = rdata_now;
    #1;
    exp_req = !r && !rd && ((outq.size() + alive_cnt()) < DEPTH);
    chk("req", {31'd0, imem_req_o}, {31'd0, exp_req});
    if (exp_req) chk("addr", imem_addr_o, pc_m);
    chk("valid", {31'd0, inst_valid_o}, {31'd0, outq.size() != 0});
    if (outq.size() != 0) begin
      chk("inst", inst_o, outq[0].inst);
      chk("inst_pc", inst_pc_o, outq[0].pc);
      chk("pc4", pc4_o, outq[0].pc + 32'd4);
    end
    @(posedge clk);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      if (rv_now) p = pend.pop_front();
      if (!rd && rdy && (outq.size() != 0)) void'(outq.pop_front());
      if (rv_now && p.alive && !rd) outq.push_back('{inst: rdata_now, pc: p.addr});
      if (rd) begin
        outq.delete();
        foreach (pend[i]) pend[i].alive = 1'b0;
        pc_m = npc & 32'hFFFF_FFFC;
      end else if (exp_req && g) begin
        pend.push_back('{addr: pc_m, alive: 1'b1, due: cyc + $urandom_range(0, lat_max)});
        pc_m = pc_m + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pend.size() != 0; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    bit r_s, rd_s, rdy_s, g_s;
    total = 0; bad = 0; cyc = 0; lat_max = 0; rnd_rv = 1'b0;
    rst = 1'b1; redirect_i = 1'b0; npc_i = 32'd0; inst_ready_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'h0000_0000);
    chk("rst_pc", inst_pc_o, 32'h0000_0000);
    chk("rst_pc4", pc4_o, 32'h0000_0004);
    chk("rst_addr", imem_addr_o, 32'h0000_3000);

    // fill with single-cycle memory and decode always ready
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("addr_second", imem_addr_o, 32'h0000_3004);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("first_pc", inst_pc_o, 32'h0000_3000);
    chk("first_pc4", pc4_o, 32'h0000_3004);
    repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // decode stalls, credits run out, then drain in order
    repeat (5) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("stall_req", {31'd0, imem_req_o}, 32'd0);
    chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // redirect with two requests in flight, misaligned target
    lat_max = 3;
    for (int i = 0; i < 20 && pend.size() < 2; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h0000_1003, 1'b1, 1'b1);
    chk("align_addr", imem_addr_o, 32'h0000_1000);
    repeat (10) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // clean redirect latency: valid in t+3
    lat_max = 0;
    drain();
    step(1'b0, 1'b1, 32'h0040_0020, 1'b1, 1'b0);
    chk("redir_addr", imem_addr_o, 32'h0040_0020);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("redir_t2_valid", {31'd0, inst_valid_o}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("redir_t3_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("redir_t3_pc", inst_pc_o, 32'h0040_0020);
    step(1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
    chk("redir_flush", {31'd0, inst_valid_o}, 32'd0);

    // PC wrap at the top of the address space
    drain();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("wrap_addr1", imem_addr_o, 32'h0000_0000);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("wrap_pc", inst_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_o, 32'h0000_0000);
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // reset in the middle of traffic
    lat_max = 2;
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("mid_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("mid_rst_inst", inst_o, 32'h0000_0000);
    chk("mid_rst_pc", inst_pc_o, 32'h0000_0000);
    chk("mid_rst_pc4", pc4_o, 32'h0000_0004);
    chk("mid_rst_addr", imem_addr_o, 32'h0000_3000);

    // random traffic
    rnd_rv = 1'b1;
    for (int i = 0; i < 800; i++) begin
      r_s   = ($urandom_range(0, 199) == 0);
      rd_s  = ($urandom_range(0, 11) == 0);
      rdy_s = ($urandom_range(0, 3) != 0);
      g_s   = ($urandom_range(0, 3) != 0);
      step(r_s, rd_s, $urandom(), rdy_s, g_s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
